// File: rtl/fifo_flow_ctrl_if.sv
// Stream-side handshake bundle: producer push valid/ready and consumer pop valid/ready.
// master = stream logic, slave = fifo_flow_ctrl.
interface fifo_flow_ctrl_if;
  logic push_valid;
  logic push_ready;
  logic pop_valid;
  logic pop_ready;

  modport master (
    output push_valid,
    output pop_ready,
    input  push_ready,
    input  pop_valid
  );

  modport slave (
    input  push_valid,
    input  pop_ready,
    output push_ready,
    output pop_valid
  );
endinterface

// File: rtl/fifo_flow_ctrl.sv
// FIFO handshake/sequencing controller: zero-latency strobes, IDLE/RUN/DRAIN FSM, occupancy, sticky errors.
// push_ready drops when full or not RUN; optional fire counters under FIFO_FLOW_CTRL_STATS_EN.
module fifo_flow_ctrl #(
  parameter int COLUMNS   = 32,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 4,
  parameter int OCC_W     = $clog2(COLUMNS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               drain_req,
  fifo_flow_ctrl_if.slave    strm,
  input  logic               full,
  input  logic               empty,
  output logic               wen,
  output logic               update_write_pointer,
  output logic               update_read_pointer,
  output logic [OCC_W-1:0]   occupancy,
  output logic [1:0]         state_o,
  output logic               drain_done,
  output logic               err_overflow,
  output logic               err_underflow
`ifdef FIFO_FLOW_CTRL_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [15:0]        push_count,
  output logic [15:0]        pop_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int SW = OCC_W + 2;
  localparam logic [SW-1:0] PW_W  = SW'(PAR_WRITE);
  localparam logic [SW-1:0] PR_W  = SW'(PAR_READ);
  localparam logic [SW-1:0] COL_W = SW'(COLUMNS);

  state_t state;

  logic in_run;
  logic in_xfer;
  logic push_fire;
  logic pop_fire;

  // Gating with rst keeps a reset cycle from committing a partial write.
  assign in_run  = (state == ST_RUN) && !rst;
  assign in_xfer = ((state == ST_RUN) || (state == ST_DRAIN)) && !rst;

  assign strm.push_ready = in_run && !full;
  assign strm.pop_valid  = in_xfer && !empty;

  assign push_fire = strm.push_valid && strm.push_ready;
  assign pop_fire  = strm.pop_valid && strm.pop_ready;

  assign wen                  = push_fire;
  assign update_write_pointer = push_fire;
  assign update_read_pointer  = pop_fire;
  assign state_o              = state;

  logic [SW-1:0]    occ_add;
  logic [SW-1:0]    occ_sub;
  logic             occ_under;
  logic             occ_over;
  logic [OCC_W-1:0] occ_nxt;

  // Counter saturates instead of wrapping; leaving range flags the matching error.
  always_comb begin
    occ_add   = {2'b00, occupancy} + (push_fire ? PW_W : '0);
    occ_under = pop_fire && (occ_add < PR_W);
    occ_sub   = occ_under ? '0 : (occ_add - (pop_fire ? PR_W : '0));
    occ_over  = (occ_sub > COL_W);
    occ_nxt   = occ_over ? OCC_W'(COLUMNS) : occ_sub[OCC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      occupancy     <= '0;
      drain_done    <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      occupancy  <= occ_nxt;
      drain_done <= 1'b0;
      if ((strm.push_valid && full && (state == ST_RUN)) || occ_over)
        err_overflow <= 1'b1;
      if ((strm.pop_ready && empty && ((state == ST_RUN) || (state == ST_DRAIN))) || occ_under)
        err_underflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (drain_req)    state <= ST_DRAIN;
          else if (!enable) state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (empty || (pop_fire && (occ_nxt == '0))) begin
            state      <= ST_IDLE;
            drain_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_FLOW_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      push_count <= '0;
      pop_count  <= '0;
    end else begin
      if (push_fire && (push_count != 16'hFFFF)) push_count <= push_count + 16'd1;
      if (pop_fire && (pop_count != 16'hFFFF))   pop_count  <= pop_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fifo_flow_ctrl.md
Name: fifo_flow_ctrl

Overview:
- Handshake and sequencing controller for the parallel-write/parallel-read FIFO datapath.
- Converts producer valid/ready and consumer valid/ready handshakes into the datapath strobes: write enable, write-pointer update and read-pointer update.
- Gates those strobes using the datapath's full/empty flags.
- Adds an enable/drain state machine, an element-occupancy counter and sticky error flags.
- Sits between the stream-side logic and the FIFO datapath; shares its clock and reset.

Parameters:
- COLUMNS, 32, usable FIFO capacity in elements; must equal the datapath COLUMNS.
- PAR_WRITE, 4, elements accepted per push; must equal the datapath PAR_WRITE.
- PAR_READ, 4, elements removed per pop; must equal the datapath PAR_READ.
- OCC_W, $clog2(COLUMNS+1), occupancy counter width (derived).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  level; start/continue normal operation.
- drain_req  input  1  pulse; stop accepting pushes and empty the FIFO.
- push_valid  input  1  producer has PAR_WRITE elements on the datapath din.
- push_ready  output  1  controller accepts a push this cycle.
- pop_valid  output  1  PAR_READ elements are valid on the datapath dout.
- pop_ready  input  1  consumer takes the elements this cycle.
- full  input  1  datapath full flag.
- empty  input  1  datapath empty flag.
- wen  output  1  datapath write enable.
- update_write_pointer  output  1  datapath write-pointer advance.
- update_read_pointer  output  1  datapath read-pointer advance.
- occupancy  output  OCC_W  elements currently stored.
- state_o  output  2  current FSM state: 0 IDLE, 1 RUN, 2 DRAIN.
- drain_done  output  1  one-cycle pulse when a drain completes.
- err_overflow  output  1  sticky; push_valid seen while full in RUN.
- err_underflow  output  1  sticky; pop_ready seen while empty in RUN or DRAIN.

Behaviour:
- Reset: state=IDLE; occupancy=0; drain_done=0; err_overflow=0; err_underflow=0.
  - All strobes are combinational functions of state and are therefore 0 in IDLE.
- FSM transitions:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0 and drain_req=0; stored data is retained.
  - RUN -> DRAIN when drain_req=1; drain_req has priority over enable=0.
  - DRAIN -> IDLE when the cycle's pop empties the FIFO, or on entry with empty=1. drain_done pulses in the cycle the state register becomes IDLE.
  - drain_req while in IDLE or DRAIN is ignored.
- push_ready = (state==RUN) && !full.
- push fire = push_valid && push_ready.
  - wen = update_write_pointer = push fire, both in the same cycle.
  - The data is written and the pointer advances at that rising edge. Zero latency; one push per cycle maximum.
- pop_valid = (state==RUN || state==DRAIN) && !empty.
- pop fire = pop_valid && pop_ready; update_read_pointer = pop fire.
  - Data must be sampled by the consumer in the fire cycle.
- Simultaneous push and pop fire in the same cycle is legal. Both strobes assert; the occupancy change is +PAR_WRITE-PAR_READ.
- occupancy update per edge: +PAR_WRITE on push fire, -PAR_READ on pop fire.
  - Never wraps. If the counter would leave the range 0..COLUMNS, it saturates and the matching error flag sets.
- Full and empty boundaries are decided by the datapath flags only; occupancy is informational.
- err_overflow sets on push_valid && full in RUN. err_underflow sets on pop_ready && empty in RUN or DRAIN. Both flags clear only on rst.
- Reset mid-transfer: all strobes deassert in the rst cycle, so no partial write is committed. The datapath pointers reset on the same edge.

Optional Feature:
- Macro FIFO_FLOW_CTRL_STATS_EN.
- Defined:
  - Adds outputs push_count[15:0] and pop_count[15:0].
  - Each counts fires, saturates at 16'hFFFF and clears on rst.
  - Adds input stats_clr, a synchronous clear that has priority over the same-cycle increment.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan (defaults):
- rst, then enable=1, push_valid=1 continuously, pop_ready=0 -> exactly 8 push fires; full=1 after the 8th; occupancy=32; push_ready=0 afterwards; err_overflow=1 on the next cycle.
- Start from full, pop_ready=1, push_valid=0 -> 8 consecutive update_read_pointer pulses; occupancy steps 28, 24, …, 0; pop_valid=0 once empty.
- occupancy=16, push_valid=1 and pop_ready=1 for 10 cycles -> wen and update_read_pointer both asserted in all 10 cycles; occupancy stays 16.
- occupancy=12, drain_req pulse with push_valid=1, pop_ready=1 -> push_ready=0 from the next cycle; 3 pops; state becomes IDLE; drain_done is a single pulse; occupancy=0.
- rst asserted in the middle of a push burst -> wen=0 in the rst cycle; state=IDLE, occupancy=0 and both error flags 0 on the next cycle.
- With FIFO_FLOW_CTRL_STATS_EN: 5 pushes and 3 pops, then stats_clr -> push_count=5 and pop_count=3 before the clear; both 0 after it.
